// File: rtl/key_strobe_conditioner_pkg.sv
// Shared constants for the push-button conditioner: debounce state encoding
// and the lab-board default timing values.
package key_strobe_conditioner_pkg;

    // Lab-board defaults: 1 ms debounce and a 0.5 s enable period at 50 MHz.
    localparam int LAB_DEBOUNCE_CYCLES = 50000;
    localparam int LAB_STROBE_DIV      = 25000000;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_e;

endpackage : key_strobe_conditioner_pkg

// File: rtl/key_strobe_conditioner_sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit, synchronous active-high reset.
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync_2ff

// File: rtl/key_strobe_conditioner.sv
// Raw push-button -> (enable, a) for the FSM labs: synchroniser, debouncer,
// rising-edge detector, strobe divider and a one-deep event latch.
// Build option: KEY_ACTIVE_LOW_EN inverts the raw key for pull-low board buttons.
module key_strobe_conditioner
    import key_strobe_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = LAB_DEBOUNCE_CYCLES,
    parameter int STROBE_DIV      = LAB_STROBE_DIV
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      key,
    output logic      enable,
    output logic      a,
    output logic      key_level,
    output logic      key_rise,
    output logic      overrun,
    output db_state_e debounce_state
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STROBE_DIV - 1);

    logic key_in;
    logic key_sync;

`ifdef KEY_ACTIVE_LOW_EN
    assign key_in = ~key;
`else
    assign key_in = key;
`endif

    sync_2ff u_sync (
        .clock (clock),
        .reset (reset),
        .d     (key_in),
        .q     (key_sync)
    );

    // ---------------- debounce FSM ----------------
    db_state_e        state_q;
    db_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= DB_STABLE;
            cnt_q     <= '0;
            key_level <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_level <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = key_level;
        case (state_q)
            DB_STABLE: begin
                if (key_sync != key_level) begin
                    // A one-cycle debounce window accepts the first differing sample.
                    if (DEBOUNCE_CYCLES == 1) begin
                        level_d = key_sync;
                        cnt_d   = '0;
                    end else begin
                        state_d = DB_COUNTING;
                        cnt_d   = CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            DB_COUNTING: begin
                if (key_sync == key_level) begin
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_d = key_sync;
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = DB_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign debounce_state = state_q;

    // ---------------- rising-edge detect ----------------
    logic level_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            level_prev <= 1'b0;
            key_rise   <= 1'b0;
        end else begin
            level_prev <= key_level;
            key_rise   <= key_level & ~level_prev;
        end
    end

    // ---------------- strobe divider ----------------
    logic [DIV_W-1:0] div_q;
    logic             div_last;

    assign div_last = (div_q == DIV_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q  <= '0;
            enable <= 1'b0;
        end else begin
            div_q  <= div_last ? '0 : div_q + DIV_W'(1);
            enable <= div_last;
        end
    end

    // ---------------- event latch ----------------
    // enable is the valid for a; there is no ready: the FSM samples a on
    // every enable cycle, so an enable cycle always drains the latch unless
    // a new rise arrives in the same cycle, in which case the new event wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            a       <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (key_rise) begin
                a <= 1'b1;
            end else if (enable) begin
                a <= 1'b0;
            end
            overrun <= key_rise & a & ~enable;
        end
    end

endmodule : key_strobe_conditioner

// File: tb/tb_key_strobe_conditioner.sv
// Self-checking bench for key_strobe_conditioner (DEBOUNCE_CYCLES=4); a second
// instance with a longer strobe period makes two presses per period reachable.
module tb_key_strobe_conditioner;
    import key_strobe_conditioner_pkg::*;

    localparam int DB   = 4;
    localparam int S1   = 5;
    localparam int S2   = 20;
    localparam int MAXK = 64;

`ifdef KEY_ACTIVE_LOW_EN
    localparam logic ACT_LOW = 1'b1;
`else
    localparam logic ACT_LOW = 1'b0;
`endif

    logic      clock;
    logic      reset;
    logic      key;
    logic      enable1, a1, key_level1, key_rise1, overrun1;
    logic      enable2, a2, key_level2, key_rise2, overrun2;
    db_state_e dbg1, dbg2;

    int n_checks = 0;
    int n_fail   = 0;

    // Vector layout: {enable, a, key_level, key_rise, overrun}
    logic [4:0] plan[0:MAXK-1];
    logic       key_plan[0:MAXK-1];
    logic [4:0] obs[0:MAXK-1];
    logic [4:0] exp_q[$];

    key_strobe_conditioner #(.DEBOUNCE_CYCLES(DB), .STROBE_DIV(S1)) u_dut (
        .clock(clock), .reset(reset), .key(key),
        .enable(enable1), .a(a1), .key_level(key_level1), .key_rise(key_rise1),
        .overrun(overrun1), .debounce_state(dbg1)
    );

    key_strobe_conditioner #(.DEBOUNCE_CYCLES(DB), .STROBE_DIV(S2)) u_dut_long (
        .clock(clock), .reset(reset), .key(key),
        .enable(enable2), .a(a2), .key_level(key_level2), .key_rise(key_rise2),
        .overrun(overrun2), .debounce_state(dbg2)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        reset = 1'b1;
        key   = ACT_LOW;
    end

    // ---------------- driver tasks ----------------
    function automatic logic [4:0] vec1();
        return {enable1, a1, key_level1, key_rise1, overrun1};
    endfunction

    function automatic logic [4:0] vec2();
        return {enable2, a2, key_level2, key_rise2, overrun2};
    endfunction

    function automatic logic [4:0] expected(input int k, input int s);
        logic [4:0] v;
        v    = plan[k];
        v[4] = (k % s == 0);
        return v;
    endfunction

    task automatic drive_key(input logic pressed);
        key = pressed ^ ACT_LOW;
    endtask

    task automatic do_reset(input logic pressed);
        @(negedge clock);
        reset = 1'b1;
        drive_key(pressed);
        repeat (3) @(negedge clock);
    endtask

    task automatic clear_plan();
        for (int k = 0; k < MAXK; k++) begin
            plan[k]     = '0;
            key_plan[k] = 1'b0;
            obs[k]      = '0;
        end
        exp_q.delete();
    endtask

    task automatic mark(input int bitpos, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) plan[k][bitpos] = 1'b1;
    endtask

    task automatic key_hold(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) key_plan[k] = 1'b1;
    endtask

    // Sample k is taken after the k-th rising edge following reset release;
    // key_plan[k] is the key level set up before that edge.
    task automatic run_window(input int n, input int s, input bit sel);
        reset = 1'b0;
        drive_key(key_plan[1]);
        exp_q.push_back(expected(1, s));
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            obs[k] = sel ? vec2() : vec1();
            if (k < n) begin
                drive_key(key_plan[k + 1]);
                exp_q.push_back(expected(k + 1, s));
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset(1'b1);
        n_checks++;
        if (vec1() !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=%b", vec1(), 5'b0);
        end
        n_checks++;
        if (vec2() !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs_long got=%b exp=%b", vec2(), 5'b0);
        end
        n_checks++;
        if (dbg1 !== DB_STABLE) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=%b", dbg1, DB_STABLE);
        end
    endtask

    task automatic test_strobe();
        clear_plan();
        do_reset(1'b0);
        run_window(16, S1, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            logic [4:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (obs[k] !== e) begin
                n_fail++;
                $display("FAIL strobe k=%0d got=%b exp=%b", k, obs[k], e);
            end
        end
    endtask

    task automatic test_press();
        clear_plan();
        key_hold(1, 20);
        mark(2, 6, 20);
        mark(1, 7, 7);
        mark(3, 8, 10);
        do_reset(1'b0);
        run_window(20, S1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            logic [4:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (obs[k] !== e) begin
                n_fail++;
                $display("FAIL press k=%0d got=%b exp=%b", k, obs[k], e);
            end
        end
    endtask

    task automatic test_glitch();
        clear_plan();
        key_hold(1, 1);
        key_hold(3, 3);
        key_hold(8, 10);
        do_reset(1'b0);
        run_window(20, S1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            logic [4:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (obs[k] !== e) begin
                n_fail++;
                $display("FAIL glitch k=%0d got=%b exp=%b", k, obs[k], e);
            end
        end
    endtask

    task automatic test_coincident();
        clear_plan();
        key_hold(4, 20);
        mark(2, 9, 20);
        mark(1, 10, 10);
        mark(3, 11, 15);
        do_reset(1'b0);
        run_window(20, S1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            logic [4:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (obs[k] !== e) begin
                n_fail++;
                $display("FAIL coincident k=%0d got=%b exp=%b", k, obs[k], e);
            end
        end
    endtask

    task automatic test_overrun();
        clear_plan();
        key_hold(14, 21);
        key_hold(30, 44);
        mark(2, 19, 26);
        mark(2, 35, 44);
        mark(1, 20, 20);
        mark(1, 36, 36);
        mark(3, 21, 40);
        mark(0, 37, 37);
        do_reset(1'b0);
        run_window(44, S2, 1'b1);
        for (int k = 1; k <= 44; k++) begin
            logic [4:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (obs[k] !== e) begin
                n_fail++;
                $display("FAIL overrun k=%0d got=%b exp=%b", k, obs[k], e);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_plan();
        key_hold(1, 9);
        mark(2, 6, 9);
        mark(1, 7, 7);
        mark(3, 8, 9);
        do_reset(1'b0);
        run_window(9, S1, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            logic [4:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (obs[k] !== e) begin
                n_fail++;
                $display("FAIL reset_mid_pre k=%0d got=%b exp=%b", k, obs[k], e);
            end
        end
        do_reset(1'b0);
        n_checks++;
        if (vec1() !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid_clear got=%b exp=%b", vec1(), 5'b0);
        end
        clear_plan();
        run_window(12, S1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            logic [4:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (obs[k] !== e) begin
                n_fail++;
                $display("FAIL reset_mid_post k=%0d got=%b exp=%b", k, obs[k], e);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_strobe();
        test_press();
        test_glitch();
        test_coincident();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_key_strobe_conditioner
